// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (IF) and data (DM) ports onto one single-ported, fixed-latency memory.
// Optional macro MEM_ARB_RR_EN: round-robin grant on a tie; default build is fixed DM-over-IF.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    output logic            if_stall,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    input  logic [DW/8-1:0] dm_be,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_ack,
    output logic            dm_stall,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    if (MEM_LAT == 0 || MEM_LAT > 15) begin : g_lat_check
        $error("mem_port_arbiter: MEM_LAT=%0d outside legal range 1..15", MEM_LAT);
    end

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    owner_t          r_owner;
    owner_t          r_last_owner;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [BW-1:0]   r_be;
    logic            r_mem_en;
    logic            r_mem_we;
    logic            r_if_ack;
    logic            r_dm_ack;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_dm_rdata;
    logic            r_busy;

    logic            w_any_req;
    logic            w_grant_dm;

    assign w_any_req = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
    // On a tie the port that did not win last time is granted.
    assign w_grant_dm = dm_req & (~if_req | (r_last_owner == OWN_IF));
`else
    assign w_grant_dm = dm_req;
`endif

    // Access sequencer: latch winner, one-cycle strobe, count latency, capture, ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner  <= w_grant_dm ? OWN_DM : OWN_IF;
                        r_addr   <= w_grant_dm ? dm_addr : if_addr;
                        r_we     <= w_grant_dm & dm_we;
                        r_be     <= (w_grant_dm && dm_we) ? dm_be : {BW{1'b1}};
                        if (w_grant_dm) begin
                            r_wdata <= dm_wdata;
                        end
                        r_mem_en <= 1'b1;
                        r_mem_we <= w_grant_dm & dm_we;
                        r_busy   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CW'(1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == CW'(MEM_LAT)) begin
                        if (!r_we) begin
                            if (r_owner == OWN_DM) begin
                                r_dm_rdata <= mem_rdata;
                            end else begin
                                r_if_rdata <= mem_rdata;
                            end
                        end
                        r_dm_ack <= (r_owner == OWN_DM);
                        r_if_ack <= (r_owner == OWN_IF);
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (r_owner != r_last_owner) begin
                        r_last_owner <= r_owner;
                    end
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_ack    = r_if_ack;
    assign if_stall  = if_req & ~r_if_ack;
    assign dm_rdata  = r_dm_rdata;
    assign dm_ack    = r_dm_ack;
    assign dm_stall  = dm_req & ~r_dm_ack;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses, expected acks/strobes queued at issue.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    logic rst_n;

    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic [BW-1:0] dm_be;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic          if_ack, if_stall, dm_ack, dm_stall, mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;

    logic          if_req1, dm_req1, dm_we1;
    logic [AW-1:0] if_addr1, dm_addr1;
    logic [DW-1:0] dm_wdata1, mem_rdata1;
    logic [BW-1:0] dm_be1;
    logic [DW-1:0] if_rdata1, dm_rdata1, mem_wdata1;
    logic          if_ack1, if_stall1, dm_ack1, dm_stall1, mem_en1, mem_we1, busy1;
    logic [AW-1:0] mem_addr1;
    logic [BW-1:0] mem_be1;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ack(if_ack1), .if_stall(if_stall1),
        .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1), .dm_be(dm_be1),
        .dm_rdata(dm_rdata1), .dm_ack(dm_ack1), .dm_stall(dm_stall1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_be(mem_be1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_dm;
        logic [31:0] rdata;
        int unsigned cyc;
    } ack_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        int unsigned cyc;
    } acc_t;

    ack_t ack_q[$];
    acc_t acc_q[$];
    ack_t e;
    acc_t m;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event missing (cycle %0d)", name, cyc);
    endtask

    // Queue one expected memory strobe at t+1+k and, optionally, its ack at t+LAT+2+k.
    task automatic expect_acc(input bit is_dm, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] be, input logic [31:0] rd,
                              input int unsigned t, input int unsigned k, input bit with_ack);
        acc_t x;
        ack_t y;
        x.addr = a; x.we = we; x.wdata = wd; x.be = be; x.cyc = t + 1 + k;
        acc_q.push_back(x);
        if (with_ack) begin
            y.is_dm = is_dm; y.rdata = rd; y.cyc = t + LAT + 2 + k;
            ack_q.push_back(y);
        end
    endtask

    // Hold a request until its ack, checking the requester's stall each cycle.
    task automatic hold(input bit is_dm, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        bit done;
        done = 1'b0;
        if (is_dm) begin
            dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be; dm_req = 1'b1;
        end else begin
            if_addr = a; if_req = 1'b1;
        end
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (is_dm ? dm_ack : if_ack) begin
                chk(is_dm ? "dm_stall_at_ack" : "if_stall_at_ack", 32'(is_dm ? dm_stall : if_stall), 32'd0);
                done = 1'b1;
            end else begin
                chk(is_dm ? "dm_stall_wait" : "if_stall_wait", 32'(is_dm ? dm_stall : if_stall), 32'd1);
            end
        end
        if (!done) fail_now("hold_timeout");
        @(posedge clk); #1;
        if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
    endtask

    // Memory models: main returns mem_val exactly LAT cycles after its strobe, dut1 one cycle after.
    bit          pv = 1'b0;
    int unsigned pc = 0;
    logic [31:0] pa = '0;
    bit          p1 = 1'b0;
    initial begin
        mem_rdata  = 32'hBAD0_BAD0;
        mem_rdata1 = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            mem_rdata  = (pv && cyc == pc) ? mem_val(pa) : 32'hBAD0_BAD0;
            mem_rdata1 = p1 ? 32'h600D_CAFE : 32'hBAD0_BAD0;
            p1 = mem_en1;
            if (mem_en) begin
                pv = 1'b1; pc = cyc + LAT; pa = mem_addr;
            end
        end
    end

    // Monitor: compare every ack and every memory strobe against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (if_ack || dm_ack) begin
                    chk("ack_overlap", 32'(if_ack & dm_ack), 32'd0);
                    if (ack_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_ack: if_ack=%b dm_ack=%b cycle %0d", if_ack, dm_ack, cyc);
                    end else begin
                        e = ack_q.pop_front();
                        chk("ack_port", 32'(dm_ack), 32'(e.is_dm));
                        chk("ack_cycle", cyc, e.cyc);
                        chk("ack_rdata", e.is_dm ? dm_rdata : if_rdata, e.rdata);
                    end
                end
                if (mem_en) begin
                    if (acc_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_mem_en: addr %h cycle %0d", mem_addr, cyc);
                    end else begin
                        m = acc_q.pop_front();
                        chk("mem_cycle", cyc, m.cyc);
                        chk("mem_addr", mem_addr, m.addr);
                        chk("mem_we", 32'(mem_we), 32'(m.we));
                        chk("mem_be", 32'(mem_be), 32'(m.be));
                        if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                    end
                end
            end
        end
    end

    int unsigned t;
    int          n_acks;
    bit          first_dm;
    bit          exp_dm;

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        if_req1 = 0; if_addr1 = '0; dm_req1 = 0; dm_we1 = 0; dm_addr1 = 32'h40; dm_wdata1 = '0; dm_be1 = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_acks", 32'({if_ack, dm_ack}), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset asserted while an access is in WAIT: abandoned, no ack.
        @(posedge clk); #1;
        t = cyc;
        expect_acc(0, 0, 32'h300, 32'h0, 4'hF, 32'h0, t, 0, 0);
        if_addr = 32'h300; if_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0; if_req = 1'b0;
        #1;
        chk("midrst_quiet", 32'({busy, mem_en, if_ack, dm_ack}), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({busy, mem_en, if_ack, dm_ack}), 32'd0);
        end

        // IF read.
        @(posedge clk); #1;
        t = cyc;
        expect_acc(0, 0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF, t, 0, 1);
        hold(0, 0, 32'h100, 32'h0, 4'hF);

        // DM load then DM store; the store must leave dm_rdata alone.
        t = cyc;
        expect_acc(1, 0, 32'h2000, 32'h0, 4'hF, 32'hC0DE_2000, t, 0, 1);
        hold(1, 0, 32'h2000, 32'h0, 4'hF);
        t = cyc;
        expect_acc(1, 1, 32'h2004, 32'h1234_5678, 4'b0011, 32'hC0DE_2000, t, 0, 1);
        hold(1, 1, 32'h2004, 32'h1234_5678, 4'b0011);
        repeat (3) @(negedge clk);
        chk("store_keeps_dm_rdata", dm_rdata, 32'hC0DE_2000);
        @(posedge clk); #1;

        // Simultaneous requests; last owner is DM at this point.
`ifdef MEM_ARB_RR_EN
        first_dm = 1'b0;
`else
        first_dm = 1'b1;
`endif
        t = cyc;
        if (first_dm) begin
            expect_acc(1, 0, 32'h2008, 32'h0, 4'hF, 32'hC0DE_2008, t, 0, 1);
            expect_acc(0, 0, 32'h104, 32'h0, 4'hF, 32'hC0DE_0104, t, 5, 1);
        end else begin
            expect_acc(0, 0, 32'h104, 32'h0, 4'hF, 32'hC0DE_0104, t, 0, 1);
            expect_acc(1, 0, 32'h2008, 32'h0, 4'hF, 32'hC0DE_2008, t, 5, 1);
        end
        fork
            hold(0, 0, 32'h104, 32'h0, 4'hF);
            hold(1, 0, 32'h2008, 32'h0, 4'hF);
        join

        // Reset so last_owner=IF, then hold both requests through four grants.
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        t = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_dm = (k % 2) == 0;
`else
            exp_dm = 1'b1;
`endif
            if (exp_dm) expect_acc(1, 0, 32'h200C, 32'h0, 4'hF, 32'hC0DE_200C, t, 5 * k, 1);
            else        expect_acc(0, 0, 32'h108, 32'h0, 4'hF, 32'hC0DE_0108, t, 5 * k, 1);
        end
        if_addr = 32'h108; dm_addr = 32'h200C; dm_we = 1'b0; dm_be = 4'hF;
        if_req = 1'b1; dm_req = 1'b1;
        n_acks = 0;
        for (int i = 0; i < 60 && n_acks < 4; i++) begin
            @(negedge clk);
            if (dm_ack) begin
                chk("nonowner_if_stall", 32'(if_stall), 32'd1);
                n_acks++;
            end else if (if_ack) begin
                chk("nonowner_dm_stall", 32'(dm_stall), 32'd1);
                n_acks++;
            end
        end
        chk("tie_ack_count", 32'(n_acks), 32'd4);
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0;

        // DM request dropped right after grant still completes once.
        @(posedge clk); #1;
        t = cyc;
        expect_acc(1, 0, 32'h2010, 32'h0, 4'hF, 32'hC0DE_2010, t, 0, 1);
        dm_addr = 32'h2010; dm_we = 1'b0; dm_req = 1'b1;
        @(posedge clk); #1 dm_req = 1'b0;
        n_acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dm_ack) n_acks++;
        end
        chk("retract_ack_count", 32'(n_acks), 32'd1);

        // MEM_LAT=1 instance: retracted load acks at request+3.
        @(posedge clk); #1;
        t = cyc;
        dm_req1 = 1'b1;
        @(posedge clk); #1 dm_req1 = 1'b0;
        @(negedge clk);
        chk("lat1_mem_en", 32'(mem_en1), 32'd1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("lat1_ack_timing", 32'(dm_ack1), 32'(cyc == t + 3));
            if (cyc == t + 3) chk("lat1_rdata", dm_rdata1, 32'h600D_CAFE);
        end

        repeat (2) @(negedge clk);
        chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
